// File: rtl/trng_stats_unit.sv
// trng_stats_unit: per-window ones/transition/longest-run statistics and a repetition-count health test
module trng_stats_unit #(
  parameter int DATA_W     = 16,
  parameter int WIN_LOG2   = 10,
  parameter int RCT_CUTOFF = 8
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_stop,
  input  logic [DATA_W-1:0] i_data_in,
  input  logic              i_data_re,
  input  logic              i_clear,
  input  logic [1:0]        i_sel,
  output logic [31:0]       o_stats,
  output logic              o_valid,
  output logic              o_alarm
);
  localparam int AW = $clog2(DATA_W) + WIN_LOG2 + 1;
  localparam int RW = $clog2(RCT_CUTOFF + 1);
  logic [WIN_LOG2-1:0] r_cnt;
  logic [AW-1:0]       r_ones, r_trans, r_cur, r_max;
  logic [AW-1:0]       r_snap_ones, r_snap_trans, r_snap_max;
  logic [DATA_W-1:0]   r_prev;
  logic [RW-1:0]       r_rep;
  logic [15:0]         r_win, r_fail;
  logic                r_valid, r_alarm;
  logic [31:0]         r_stats;
  logic                w_acc, w_pred, w_last, w_same, w_trip;
  logic [AW-1:0]       w_pop, w_tw, w_run, w_mx;
  logic [RW-1:0]       w_rep_nx;
  logic [31:0]         w_stats;
  assign w_acc  = i_data_re & ~i_stop & ~i_clear;
  assign w_pred = r_cnt != '0;
  assign w_last = &r_cnt;
  // The previous word only links into this one when it belongs to the same window
  always_comb begin
    w_pop = AW'(i_data_in[0]);
    w_tw  = (w_pred && i_data_in[0] != r_prev[DATA_W-1]) ? AW'(1) : '0;
    w_run = (w_pred && i_data_in[0] == r_prev[DATA_W-1]) ? r_cur + AW'(1) : AW'(1);
    w_mx  = (w_run > r_max) ? w_run : r_max;
    for (int k = 1; k < DATA_W; k++) begin
      w_pop = w_pop + AW'(i_data_in[k]);
      w_tw  = w_tw + AW'(i_data_in[k] != i_data_in[k-1]);
      w_run = (i_data_in[k] == i_data_in[k-1]) ? w_run + AW'(1) : AW'(1);
      w_mx  = (w_run > w_mx) ? w_run : w_mx;
    end
  end
  assign w_same   = (r_rep != '0) && (i_data_in == r_prev);
  assign w_rep_nx = !w_same ? RW'(1) : (r_rep == RW'(RCT_CUTOFF)) ? r_rep : r_rep + RW'(1);
  assign w_trip   = (w_rep_nx == RW'(RCT_CUTOFF)) && (r_rep != RW'(RCT_CUTOFF));
  always_comb begin
    w_stats = i_sel == 2'd0 ? 32'(r_snap_ones) :
              i_sel == 2'd1 ? 32'(r_snap_trans) :
              i_sel == 2'd2 ? 32'(r_snap_max) : {r_win, r_fail};
  end
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt        <= '0;
      r_ones       <= '0;
      r_trans      <= '0;
      r_cur        <= '0;
      r_max        <= '0;
      r_snap_ones  <= '0;
      r_snap_trans <= '0;
      r_snap_max   <= '0;
      r_prev       <= '0;
      r_rep        <= '0;
      r_win        <= '0;
      r_fail       <= '0;
      r_valid      <= 1'b0;
      r_alarm      <= 1'b0;
      r_stats      <= '0;
    end else begin
      r_stats <= w_stats;
      if (i_clear) begin
        r_cnt        <= '0;
        r_ones       <= '0;
        r_trans      <= '0;
        r_cur        <= '0;
        r_max        <= '0;
        r_snap_ones  <= '0;
        r_snap_trans <= '0;
        r_snap_max   <= '0;
        r_prev       <= '0;
        r_rep        <= '0;
        r_win        <= '0;
        r_fail       <= '0;
        r_valid      <= 1'b0;
        r_alarm      <= 1'b0;
      end else if (w_acc) begin
        r_cnt  <= r_cnt + WIN_LOG2'(1);
        r_prev <= i_data_in;
        r_rep  <= w_rep_nx;
        if (w_trip) begin
          r_alarm <= 1'b1;
          r_fail  <= (&r_fail) ? r_fail : r_fail + 16'd1;
        end
        if (w_last) begin
          r_snap_ones  <= r_ones + w_pop;
          r_snap_trans <= r_trans + w_tw;
          r_snap_max   <= w_mx;
          r_ones       <= '0;
          r_trans      <= '0;
          r_cur        <= '0;
          r_max        <= '0;
          r_win        <= (&r_win) ? r_win : r_win + 16'd1;
          r_valid      <= 1'b1;
        end else begin
          r_ones  <= r_ones + w_pop;
          r_trans <= r_trans + w_tw;
          r_cur   <= w_run;
          r_max   <= w_mx;
        end
      end
    end
  end
  assign o_stats = r_stats;
  assign o_valid = r_valid;
  assign o_alarm = r_alarm;
endmodule
